// File: rtl/powlib_dnfifo_pkg.sv
// Shared helpers for the wide-to-narrow FIFO: width math, parameter legality
// and slice addressing.
package powlib_dnfifo_pkg;

   localparam int MULT_MIN = 1;
   localparam int MULT_MAX = 16;

   // Bits needed to index v items; never less than 1 so single-item cases
   // still get a real signal.
   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic bit mult_ok(input int m);
      return (m >= MULT_MIN) && (m <= MULT_MAX);
   endfunction

   function automatic bit depth_ok(input int d);
      return (d >= 2) && ((d & (d - 1)) == 0);
   endfunction

   // LSB position of narrow slice idx inside a wide word.
   function automatic int slice_lsb(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/powlib_dnfifo_buf.sv
// Circular D-entry buffer of wide words with registered pointers and count.
module powlib_dnfifo_buf
   import powlib_dnfifo_pkg::*;
#(
   parameter int DW = 64,
   parameter int D  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            head,
   output logic [clog2_min1(D):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = clog2_min1(D);

   logic [DW-1:0] mem_q [D];
   logic [DW-1:0] mem_d [D];
   logic [AW-1:0] wrptr_q, wrptr_d;
   logic [AW-1:0] rdptr_q, rdptr_d;
   logic [AW:0]   count_q, count_d;

   // D is a power of two, so plain AW-bit increment wraps modulo D.
   always_comb begin
      mem_d   = mem_q;
      wrptr_d = wrptr_q;
      rdptr_d = rdptr_q;
      count_d = count_q;
      if (push) begin
         mem_d[wrptr_q] = wdata;
         wrptr_d        = wrptr_q + 1'b1;
      end
      if (pop) rdptr_d = rdptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < D; i++) mem_q[i] <= '0;
         wrptr_q <= '0;
         rdptr_q <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wrptr_q <= wrptr_d;
         rdptr_q <= rdptr_d;
         count_q <= count_d;
      end
   end

   assign head  = mem_q[rdptr_q];
   assign count = count_q;
   assign full  = count_q[AW];
   assign empty = (count_q == '0);

endmodule

// File: rtl/powlib_dnfifo.sv
// Width down-converter: buffers W*MULT-bit words and emits them as MULT
// narrow W-bit words, least-significant slice first.
module powlib_dnfifo
   import powlib_dnfifo_pkg::*;
#(
   parameter int    W    = 16,
   parameter int    MULT = 4,
   parameter int    D    = 4,
   parameter string ID   = "DNFIFO",
   parameter int    EDBG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W*MULT-1:0] wrdata,
   input  logic              wrvld,
   output logic              wrrdy,
   output logic [W-1:0]      rddata,
   output logic              rdvld,
   input  logic              rdrdy
);

   localparam int            AW   = clog2_min1(D);
   localparam int            IW   = clog2_min1(MULT);
   localparam logic [IW-1:0] LAST = IW'(MULT - 1);

   if (!mult_ok(MULT)) begin : g_bad_mult
      $error("%s: MULT must be in 1..16", ID);
   end
   if (!depth_ok(D)) begin : g_bad_depth
      $error("%s: D must be a power of two >= 2", ID);
   end
   if (EDBG != 0 && EDBG != 1) begin : g_bad_edbg
      $error("%s: EDBG must be 0 or 1", ID);
   end

   logic [W*MULT-1:0] head;
   logic [AW:0]       count;
   logic              full, empty;
   logic              push, pop, rd_fire;
   logic [IW-1:0]     idx_q, idx_d;
   logic              rdy_q, rdy_d;

   // rdy_q keeps wrrdy low during reset and for the first edge after release.
   assign rdy_d   = 1'b1;
   assign wrrdy   = rdy_q & ~full;
   assign rdvld   = ~empty;
   assign push    = wrvld & wrrdy;
   assign rd_fire = rdvld & rdrdy;
   assign pop     = rd_fire & (idx_q == LAST);

   always_comb begin
      idx_d = idx_q;
      if (rd_fire) idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
   end

   always_comb begin
      rddata = '0;
      if (!empty) rddata = W'(head >> slice_lsb(int'(idx_q), W));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         rdy_q <= rdy_d;
      end
   end

   powlib_dnfifo_buf #(.DW(W*MULT), .D(D)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (wrdata),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_powlib_dnfifo.sv
// Directed bench for powlib_dnfifo: W=16/MULT=4/D=4 plus a MULT=1/D=2 instance.
module tb_powlib_dnfifo;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [63:0] wrdata = '0;
   logic        wrvld = 1'b0, rdrdy = 1'b0;
   logic        wrrdy, rdvld;
   logic [15:0] rddata;

   logic [15:0] wrdata1 = '0;
   logic        wrvld1 = 1'b0, rdrdy1 = 1'b0;
   logic        wrrdy1, rdvld1;
   logic [15:0] rddata1;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   powlib_dnfifo #(.W(16), .MULT(4), .D(4)) dut (
      .clk(clk), .rst(rst), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
      .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy)
   );

   powlib_dnfifo #(.W(16), .MULT(1), .D(2), .ID("DNFIFO1")) dut1 (
      .clk(clk), .rst(rst), .wrdata(wrdata1), .wrvld(wrvld1), .wrrdy(wrrdy1),
      .rddata(rddata1), .rdvld(rdvld1), .rdrdy(rdrdy1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] sl(input logic [63:0] w, input int k);
      return w[k*16 +: 16];
   endfunction

   logic [63:0] wd [7];
   logic [15:0] expq [$];
   logic [15:0] prev_data;
   logic        prev_hold;
   logic [63:0] word;
   int          nw, cyc;

   initial begin
      wd[0] = 64'h0A03_0A02_0A01_0A00;
      wd[1] = 64'h0B03_0B02_0B01_0B00;
      wd[2] = 64'h0C03_0C02_0C01_0C00;
      wd[3] = 64'h0D03_0D02_0D01_0D00;
      wd[4] = 64'hDEAD_DEAD_DEAD_DEAD;
      wd[5] = 64'h0E03_0E02_0E01_0E00;
      wd[6] = 64'hBAD0_BAD0_BAD0_BAD0;

      // Reset state
      #2;
      chk("rst_wrrdy", wrrdy, 0);
      chk("rst_rdvld", rdvld, 0);
      chk("rst_rddata", rddata, 0);
      chk("rst_wrrdy1", wrrdy1, 0);
      step();
      rst = 1'b1;
      step();
      chk("rel_wrrdy", wrrdy, 1);
      chk("rel_rdvld", rdvld, 0);

      // Single word, rdrdy held high
      wrdata = 64'h4444_3333_2222_1111;
      wrvld = 1'b1;
      rdrdy = 1'b1;
      step();
      wrvld = 1'b0;
      chk("single_vld0", rdvld, 1);
      chk("single_s0", rddata, 16'h1111);
      step();
      chk("single_s1", rddata, 16'h2222);
      step();
      chk("single_s2", rddata, 16'h3333);
      step();
      chk("single_s3", rddata, 16'h4444);
      step();
      chk("single_end_vld", rdvld, 0);
      chk("single_end_data", rddata, 0);

      // Fill: five back-to-back writes, fifth refused
      rdrdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wrdata = wd[i];
         wrvld = 1'b1;
         chk($sformatf("fill_wrrdy%0d", i), wrrdy, (i < 4) ? 1 : 0);
         step();
         chk($sformatf("fill_hold%0d", i), rddata, 16'h0A00);
      end
      wrvld = 1'b0;

      // Full: stream out word 0, then write while pop frees one slot
      rdrdy = 1'b1;
      chk("full_s0", rddata, 16'h0A00);
      step();
      step();
      step();
      chk("full_idx3_data", rddata, 16'h0A03);
      chk("full_idx3_wrrdy", wrrdy, 0);
      step();
      chk("full_pop_wrrdy", wrrdy, 1);
      chk("full_pop_data", rddata, 16'h0B00);
      wrdata = wd[5];
      wrvld = 1'b1;
      step();
      wrvld = 1'b0;
      chk("full_refill_wrrdy", wrrdy, 0);
      chk("full_refill_data", rddata, 16'h0B01);
      step();
      step();
      wrdata = wd[6];
      wrvld = 1'b1;
      chk("full_ign_data", rddata, 16'h0B03);
      step();
      wrvld = 1'b0;
      chk("full_ign_wrrdy", wrrdy, 1);
      for (int w = 0; w < 3; w++) begin
         word = (w == 0) ? wd[2] : (w == 1) ? wd[3] : wd[5];
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_w%0d_s%0d", w, k), rddata, sl(word, k));
            step();
         end
      end
      chk("drain_empty", rdvld, 0);

      // Backpressure: 32 words, random rdrdy, scoreboard of slices
      nw = 0;
      cyc = 0;
      prev_hold = 1'b0;
      prev_data = '0;
      while ((nw < 32 || expq.size() != 0) && cyc < 2000) begin
         if (prev_hold) begin
            chk("bp_hold_vld", rdvld, 1);
            chk("bp_hold_data", rddata, prev_data);
         end
         word = {16'(nw * 4 + 3 + 16'h100), 16'(nw * 4 + 2 + 16'h100),
                 16'(nw * 4 + 1 + 16'h100), 16'(nw * 4 + 16'h100)};
         wrvld = (nw < 32) && ($urandom_range(0, 3) != 0);
         wrdata = word;
         rdrdy = $urandom_range(0, 1);
         if (rdvld && rdrdy) begin
            if (expq.size() == 0) chk("bp_unexpected", rddata, 16'hxxxx);
            else chk("bp_data", rddata, expq.pop_front());
         end
         if (wrvld && wrrdy) begin
            for (int k = 0; k < 4; k++) expq.push_back(sl(word, k));
            nw++;
         end
         prev_hold = rdvld && !rdrdy;
         prev_data = rddata;
         step();
         cyc++;
      end
      chk("bp_done", (cyc < 2000) ? 1 : 0, 1);
      wrvld = 1'b0;
      rdrdy = 1'b0;
      step();
      chk("bp_empty", rdvld, 0);

      // Reset mid-word
      wrdata = 64'hDDDD_CCCC_BBBB_AAAA;
      wrvld = 1'b1;
      rdrdy = 1'b1;
      step();
      wrvld = 1'b0;
      chk("rmw_s0", rddata, 16'hAAAA);
      step();
      step();
      chk("rmw_s2", rddata, 16'hCCCC);
      rst = 1'b0;
      #1;
      chk("rmw_rst_vld", rdvld, 0);
      chk("rmw_rst_wrrdy", wrrdy, 0);
      chk("rmw_rst_data", rddata, 0);
      step();
      rst = 1'b1;
      step();
      chk("rmw_rel_wrrdy", wrrdy, 1);
      chk("rmw_rel_vld", rdvld, 0);
      wrdata = 64'h0008_0007_0006_0005;
      wrvld = 1'b1;
      step();
      wrvld = 1'b0;
      chk("rmw_next_s0", rddata, 16'h0005);
      step();
      chk("rmw_next_s1", rddata, 16'h0006);
      step();
      step();
      step();
      chk("rmw_next_empty", rdvld, 0);

      // MULT=1, D=2 pass-through
      rdrdy1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wrdata1 = 16'hA000 + 16'(i);
         wrvld1 = 1'b1;
         chk($sformatf("m1_wrrdy%0d", i), wrrdy1, 1);
         step();
         chk($sformatf("m1_vld%0d", i), rdvld1, 1);
         chk($sformatf("m1_data%0d", i), rddata1, 16'hA000 + 16'(i));
      end
      wrvld1 = 1'b0;
      step();
      chk("m1_empty", rdvld1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
